// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: divider state encoding, default width
// and the most-negative-integer helper.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    // Widths up to 64 bits are supported; callers keep the low 'width' bits.
    function automatic logic [63:0] min_int(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/sub_ripple.sv
// N-bit ripple-borrow subtractor: a - b computed as a + ~b + 1 through a chain
// of full adders; borrow is the inverted final carry (set when a < b unsigned).
module sub_ripple
    import alu_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic carry;

    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int i = 0; i < N; i++) begin
            diff[i] = a[i] ^ ~b[i] ^ carry;
            carry   = (a[i] & ~b[i]) | (carry & (a[i] ^ ~b[i]));
        end
        borrow = ~carry;
    end

endmodule

// File: rtl/div_seq_restoring.sv
// Multi-cycle restoring divider: one quotient bit per clock by trial
// subtraction, with sign handling done on magnitudes before and after the loop.
module div_seq_restoring
    import alu_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [63:0]      MIN_WIDE = min_int(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT  = MIN_WIDE[WIDTH-1:0];

    div_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             fix_hold;
    logic [WIDTH-1:0] rem_acc, quo_acc, div_mag;
    logic             neg_quo, neg_rem, dz;

    logic [WIDTH-1:0] neg_a_in, neg_b_in, neg_a_out, neg_b_out;
    logic             neg_a_borrow_unused, neg_b_borrow;
    logic             dividend_neg, divisor_neg;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;

    logic [WIDTH:0]   trial_a, trial_diff;
    logic             trial_borrow, trial_sign_unused;

    // The two negators take the operands while idle and the raw results in FIX.
    assign neg_a_in = (state == ST_IDLE) ? dividend : quo_acc;
    assign neg_b_in = (state == ST_IDLE) ? divisor  : rem_acc;

    sub_ripple #(.N(WIDTH)) u_neg_a (
        .a      ('0),
        .b      (neg_a_in),
        .diff   (neg_a_out),
        .borrow (neg_a_borrow_unused)
    );

    sub_ripple #(.N(WIDTH)) u_neg_b (
        .a      ('0),
        .b      (neg_b_in),
        .diff   (neg_b_out),
        .borrow (neg_b_borrow)
    );

    assign dividend_neg = SIGNED && ((dividend & MIN_INT) != '0);
    assign divisor_neg  = SIGNED && ((divisor & MIN_INT) != '0);
    assign dividend_mag = dividend_neg ? neg_a_out : dividend;
    assign divisor_mag  = divisor_neg  ? neg_b_out : divisor;

    assign trial_a           = {rem_acc, quo_acc[WIDTH-1]};
    assign trial_sign_unused = trial_diff[WIDTH];

    sub_ripple #(.N(WIDTH + 1)) u_trial (
        .a      (trial_a),
        .b      ({1'b0, div_mag}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    assign busy = (state != ST_IDLE);

    // While idle, 0 - divisor borrows exactly when the divisor is non-zero.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = neg_b_borrow ? ST_RUN : ST_FIX;
            ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_FIX;
            ST_FIX:  if (!fix_hold) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Divide-by-zero lingers one extra cycle in FIX (fix_hold) to give done at k+2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            fix_hold    <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    cnt         <= '0;
                    fix_hold    <= ~neg_b_borrow;
                    div_by_zero <= 1'b0;
                end
                ST_RUN: cnt <= cnt + 1'b1;
                ST_FIX: if (fix_hold) begin
                    fix_hold <= 1'b0;
                end else begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    quotient    <= neg_quo ? neg_a_out : quo_acc;
                    remainder   <= neg_rem ? neg_b_out : rem_acc;
                end
                default: ;
            endcase
        end
    end

    // A zero divisor preloads R=|dividend|, Q=0 so FIX restores the dividend.
    always_ff @(posedge clock) begin
        case (state)
            ST_IDLE: if (start) begin
                div_mag <= divisor_mag;
                neg_quo <= dividend_neg ^ divisor_neg;
                neg_rem <= dividend_neg;
                dz      <= ~neg_b_borrow;
                if (neg_b_borrow) begin
                    rem_acc <= '0;
                    quo_acc <= dividend_mag;
                end else begin
                    rem_acc <= dividend_mag;
                    quo_acc <= '0;
                end
            end
            ST_RUN: begin
                quo_acc <= {quo_acc[WIDTH-2:0], ~trial_borrow};
                rem_acc <= trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_seq_restoring.sv
// Bench for div_seq_restoring: a signed and an unsigned 32-bit instance driven
// from a table of hand-computed vectors plus directed multi-cycle sequences.
module tb_div_seq_restoring;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_s = 1'b0;
    logic        start_u = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        busy_s, done_s, dz_s, busy_u, done_u, dz_u;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_seq_restoring #(.WIDTH(32), .SIGNED(1'b1)) u_dut_s (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_s),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quo_s),
        .remainder   (rem_s),
        .busy        (busy_s),
        .done        (done_s),
        .div_by_zero (dz_s)
    );

    div_seq_restoring #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_u),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quo_u),
        .remainder   (rem_u),
        .busy        (busy_u),
        .done        (done_u),
        .div_by_zero (dz_u)
    );

    typedef struct {
        logic        sel_u;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Leaves the caller 1 time unit after the accepting edge with operands scrambled.
    task automatic accept(input logic sel_u, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        if (sel_u) start_u = 1'b1;
        else       start_s = 1'b1;
        @(posedge clock);
        #1;
        start_s  = 1'b0;
        start_u  = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
    endtask

    task automatic wait_done(input logic sel_u, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int n = 0; n <= 100; n++) begin
            if (n > 0) begin
                @(posedge clock);
                #1;
            end
            if (sel_u ? done_u : done_s) begin
                lat = n;
                break;
            end
            if (sel_u ? busy_u : busy_s) busy_cycles++;
        end
    endtask

    task automatic run_op(input logic sel_u, input string name,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r,
                          input logic dz, input int lat_exp);
        int lat, bc;
        accept(sel_u, a, b);
        wait_done(sel_u, lat, bc);
        check({name, "_latency"}, 32'(lat), 32'(lat_exp));
        check({name, "_busy_cycles"}, 32'(bc), 32'(lat_exp));
        check({name, "_busy_at_done"}, 32'(sel_u ? busy_u : busy_s), 32'd0);
        check({name, "_quotient"}, sel_u ? quo_u : quo_s, q);
        check({name, "_remainder"}, sel_u ? rem_u : rem_s, r);
        check({name, "_div_by_zero"}, 32'(sel_u ? dz_u : dz_s), 32'(dz));
    endtask

    initial begin
        int lat, pulses;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, "t1_100_div_7"};
        vecs[1]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33, "t2_m7_div_2"};
        vecs[2]  = '{1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33, "t2_7_div_m2"};
        vecs[3]  = '{1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 33, "t2_m7_div_m2"};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd5,          1'b1, 2,  "t3_5_div_0"};
        vecs[5]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33, "t3_9_div_3"};
        vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33, "t4_min_div_m1"};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFB,  32'd0,          32'd0,          32'hFFFF_FFFB,  1'b1, 2,  "t3_m5_div_0"};
        vecs[8]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33, "zero_div_5"};
        vecs[9]  = '{1'b0, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 33, "min_div_2"};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33, "t4_u_max_div_1"};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5,          1'b0, 33, "u_max_div_10"};
        vecs[12] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33, "u_big_div_max"};
        vecs[13] = '{1'b1, 32'd7,          32'd0,          32'd0,          32'd7,          1'b1, 2,  "u_7_div_0"};

        // Reset state
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy_s), 32'd0);
        check("reset_done", 32'(done_s), 32'd0);
        check("reset_dz", 32'(dz_s), 32'd0);
        check("reset_quotient", quo_s, 32'd0);
        check("reset_remainder", rem_s, 32'd0);
        check("reset_u_quotient", quo_u, 32'd0);
        check("reset_u_remainder", rem_u, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].sel_u, vecs[i].name, vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

        // Start while busy is ignored
        accept(1'b0, 32'd100, 32'd7);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            start_s  = (n == 10);
            dividend = 32'd50;
            divisor  = 32'd5;
            @(posedge clock);
            #1;
            start_s = 1'b0;
            if (done_s) begin
                lat = n;
                break;
            end
        end
        check("t5_ignored_latency", 32'(lat), 32'd33);
        check("t5_ignored_quotient", quo_s, 32'd14);
        check("t5_ignored_remainder", rem_s, 32'd2);

        // Start in the done cycle is accepted
        run_op(1'b0, "t5_back_to_back", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

        // Reset mid-operation
        accept(1'b0, 32'd100, 32'd7);
        repeat (11) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t6_abort_busy", 32'(busy_s), 32'd0);
        check("t6_abort_done", 32'(done_s), 32'd0);
        check("t6_abort_quotient", quo_s, 32'd0);
        check("t6_abort_remainder", rem_s, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done_s) pulses++;
        end
        check("t6_no_done_after_abort", 32'(pulses), 32'd0);
        run_op(1'b0, "t6_after_reset", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
